// File: rtl/alu_exec_ctrl.sv
// ============================================================================
// Module   : alu_exec_ctrl
// Brief    : Execute-stage controller that fetches operands from a register
//            file, drives an external ALU and writes the result back.
//            Optional macro ALU_DIVZERO_TRAP_EN enables a sticky trap on
//            divide or modulo by zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_ctrl #(
  parameter int N  = 32,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_opcode,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [N-1:0]  in_imm,
  output logic [3:0]    alu_opcode,
  output logic [N-1:0]  alu_op_a,
  output logic [N-1:0]  alu_op_b,
  input  logic [N-1:0]  alu_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_err
);

  localparam int NREG = 1 << AW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_TRAP = 2'd3;

  localparam logic [3:0] OP_DIV   = 4'd7;
  localparam logic [3:0] OP_MOD   = 4'd8;
  localparam logic [3:0] OP_LOADI = 4'd14;
  localparam logic [3:0] OP_READ  = 4'd15;

  logic [1:0]    state_q, state_d;
  logic [3:0]    alu_opcode_q, alu_opcode_d;
  logic [N-1:0]  alu_op_a_q, alu_op_a_d;
  logic [N-1:0]  alu_op_b_q, alu_op_b_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [N-1:0]  imm_q, imm_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic          out_err_q, out_err_d;
  logic [N-1:0]  rf_q [NREG];
  logic [N-1:0]  rf_d [NREG];

  logic [N-1:0]  exec_res;
  logic          exec_err;
  logic          exec_wb;
  logic          b_zero;
  logic          accept;
`ifdef ALU_DIVZERO_TRAP_EN
  logic          trap_q, trap_d;
  logic          exec_trap;
`endif

  assign accept = in_valid && (state_q == S_IDLE);
  assign b_zero = (alu_op_b_q == '0);

  // Result selection for the instruction currently in EXEC.
  always_comb begin
    exec_res = '0;
    exec_err = 1'b0;
`ifdef ALU_DIVZERO_TRAP_EN
    exec_trap = 1'b0;
`endif
    case (alu_opcode_q)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: exec_res = alu_result;
      OP_DIV, OP_MOD: begin
        if (b_zero) begin
          exec_err = 1'b1;
`ifdef ALU_DIVZERO_TRAP_EN
          exec_res  = '0;
          exec_trap = 1'b1;
`else
          exec_res  = (alu_opcode_q == OP_DIV) ? {N{1'b1}} : alu_op_a_q;
`endif
        end else begin
          exec_res = alu_result;
        end
      end
      OP_LOADI: exec_res = imm_q;
      OP_READ:  exec_res = alu_op_a_q;
      default: begin
        exec_res = '0;
        exec_err = 1'b1;
      end
    endcase
  end

  assign exec_wb = (state_q == S_EXEC) && !exec_err &&
                   (alu_opcode_q != OP_READ) && (rd_q != '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = S_EXEC;
      S_EXEC: state_d = S_RESP;
      S_RESP: begin
        if (out_ready) begin
`ifdef ALU_DIVZERO_TRAP_EN
          state_d = trap_q ? S_TRAP : S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef ALU_DIVZERO_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_RESP);
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_op_a   = alu_op_a_q;
  assign alu_op_b   = alu_op_b_q;
  assign out_data   = out_data_q;
  assign out_err    = out_err_q;

  // Datapath next values
  always_comb begin
    alu_opcode_d = alu_opcode_q;
    alu_op_a_d   = alu_op_a_q;
    alu_op_b_d   = alu_op_b_q;
    rd_d         = rd_q;
    imm_d        = imm_q;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    rf_d         = rf_q;
`ifdef ALU_DIVZERO_TRAP_EN
    trap_d       = trap_q;
`endif
    if (accept) begin
      alu_opcode_d = in_opcode;
      alu_op_a_d   = (in_rs1 == '0) ? '0 : rf_q[in_rs1];
      alu_op_b_d   = (in_rs2 == '0) ? '0 : rf_q[in_rs2];
      rd_d         = in_rd;
      imm_d        = in_imm;
    end
    if (state_q == S_EXEC) begin
      out_data_d = exec_res;
      out_err_d  = exec_err;
`ifdef ALU_DIVZERO_TRAP_EN
      trap_d     = exec_trap;
`endif
    end
    if (exec_wb) rf_d[rd_q] = exec_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode_q <= '0;
      alu_op_a_q   <= '0;
      alu_op_b_q   <= '0;
      rd_q         <= '0;
      imm_q        <= '0;
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
`ifdef ALU_DIVZERO_TRAP_EN
      trap_q       <= 1'b0;
`endif
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      alu_opcode_q <= alu_opcode_d;
      alu_op_a_q   <= alu_op_a_d;
      alu_op_b_q   <= alu_op_b_d;
      rd_q         <= rd_d;
      imm_q        <= imm_d;
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
`ifdef ALU_DIVZERO_TRAP_EN
      trap_q       <= trap_d;
`endif
      for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
    end
  end

endmodule

`default_nettype wire
